// File: rtl/nand_page_program_engine.sv
// Reads one 2048-word page from the buffer's controller port and drives an x16 NAND PAGE PROGRAM
// (0x80, 4 address cycles, data, 0x10), then waits on R/B#. Optional timeout: NAND_BUSY_TIMEOUT_EN.
module nand_page_program_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUF_DEPTH    = 2048,
  parameter int ADDR_WIDTH   = 11,
  parameter int ROW_WIDTH    = 16,
  parameter int WE_LOW_CYC   = 2,
  parameter int WE_HIGH_CYC  = 2,
  parameter int WB_CYC       = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_WIDTH-1:0]  row_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic [DATA_WIDTH-1:0] nand_io_out,
  output logic                  nand_io_oe,
  output logic                  nand_ce_n,
  output logic                  nand_cle,
  output logic                  nand_ale,
  output logic                  nand_we_n,
  input  logic                  nand_rb_n
);

  localparam int BUS = WE_LOW_CYC + WE_HIGH_CYC;
  localparam int PW  = (BUS > 1) ? $clog2(BUS) : 1;
  localparam int WW  = $clog2(WB_CYC + 1);
  localparam logic [PW-1:0]         PH_LAST = PW'(BUS - 1);
  localparam logic [PW-1:0]         PH_PRE  = PW'(BUS - 2);
  localparam logic [PW-1:0]         PH_RISE = PW'(WE_LOW_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] W_LAST  = ADDR_WIDTH'(BUF_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2, S_WAIT_BUSY, S_WAIT_READY, S_DONE
  } state_t;

  state_t                state;
  logic [PW-1:0]         ph;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WW-1:0]         wcnt;
  logic [ROW_WIDTH-1:0]  row_q;
  logic [DATA_WIDTH-1:0] io_q;
  logic                  in_data;
  logic                  rb_s1, rb_s2;
  logic                  bus_state, fetch_due;

  // The buffer's read register updates exactly on the bus-cycle boundary and then holds,
  // so during DATA it serves directly as the I/O drive register.
  assign nand_io_out = in_data ? buf_rd_data : io_q;

  assign bus_state = (state == S_CMD1) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CMD2);
  assign fetch_due = ((state == S_ADDR) && (idx == ADDR_WIDTH'(3))) ||
                     ((state == S_DATA) && (idx != W_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_s1 <= 1'b0;
      rb_s2 <= 1'b0;
    end else begin
      rb_s1 <= nand_rb_n;
      rb_s2 <= rb_s1;
    end
  end

`ifdef NAND_BUSY_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign fail = 1'b0 & (BUSY_TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ph          <= '0;
      idx         <= '0;
      wcnt        <= '0;
      row_q       <= '0;
      io_q        <= '0;
      in_data     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      nand_io_oe  <= 1'b0;
      nand_ce_n   <= 1'b1;
      nand_cle    <= 1'b0;
      nand_ale    <= 1'b0;
      nand_we_n   <= 1'b1;
`ifdef NAND_BUSY_TIMEOUT_EN
      tcnt        <= '0;
      fail        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef NAND_BUSY_TIMEOUT_EN
      fail <= 1'b0;
`endif
      // Fetch the next word so it lands on the boundary into the following bus cycle.
      buf_rd_en <= fetch_due && (ph == PH_PRE);
      if (buf_rd_en) buf_rd_addr <= buf_rd_addr + 1'b1;

      if (bus_state) begin
        if (ph == PH_LAST) begin
          ph <= '0;
          if (state != S_CMD2) nand_we_n <= 1'b0;
        end else begin
          ph <= ph + 1'b1;
          if (ph == PH_RISE) nand_we_n <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            row_q      <= row_addr;
            busy       <= 1'b1;
            nand_ce_n  <= 1'b0;
            nand_io_oe <= 1'b1;
            io_q       <= DATA_WIDTH'(16'h0080);
            nand_cle   <= 1'b1;
            nand_ale   <= 1'b0;
            nand_we_n  <= 1'b0;
            ph         <= '0;
            state      <= S_CMD1;
          end
        end
        S_CMD1: begin
          if (ph == PH_LAST) begin
            idx      <= '0;
            io_q     <= '0;
            nand_cle <= 1'b0;
            nand_ale <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ph == PH_LAST) begin
            if (idx == ADDR_WIDTH'(3)) begin
              idx      <= '0;
              io_q     <= '0;
              nand_ale <= 1'b0;
              in_data  <= 1'b1;
              state    <= S_DATA;
            end else begin
              idx  <= idx + 1'b1;
              io_q <= (idx == ADDR_WIDTH'(1)) ? DATA_WIDTH'(row_q[7:0]) :
                      (idx == ADDR_WIDTH'(2)) ? DATA_WIDTH'(row_q[15:8]) : '0;
            end
          end
        end
        S_DATA: begin
          if (ph == PH_LAST) begin
            if (idx == W_LAST) begin
              idx      <= '0;
              in_data  <= 1'b0;
              io_q     <= DATA_WIDTH'(16'h0010);
              nand_cle <= 1'b1;
              state    <= S_CMD2;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_CMD2: begin
          if (ph == PH_LAST) begin
            nand_io_oe <= 1'b0;
            nand_cle   <= 1'b0;
            io_q       <= '0;
            wcnt       <= '0;
            state      <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (wcnt == WW'(WB_CYC - 1)) begin
            wcnt  <= '0;
            state <= S_WAIT_READY;
`ifdef NAND_BUSY_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WAIT_READY: begin
          // A device that is already ready here is accepted; no low phase is required.
          if (rb_s2) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            nand_ce_n <= 1'b1;
            state     <= S_DONE;
          end
`ifdef NAND_BUSY_TIMEOUT_EN
          else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
            fail      <= 1'b1;
            busy      <= 1'b0;
            nand_ce_n <= 1'b1;
            tcnt      <= '0;
            state     <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
